// File: rtl/pit8253_lite_pkg.sv
// Shared constants for the lite 8253 timer: counter modes, read/write
// access encodings, port offsets and the control-word mode mapping.
package pit_pkg;

    // Counter modes actually implemented
    localparam logic [1:0] MODE_IRQ  = 2'd0;
    localparam logic [1:0] MODE_RATE = 2'd2;
    localparam logic [1:0] MODE_SQW  = 2'd3;

    // RW field of the control word
    localparam logic [1:0] RW_LATCH = 2'd0;
    localparam logic [1:0] RW_LSB   = 2'd1;
    localparam logic [1:0] RW_MSB   = 2'd2;
    localparam logic [1:0] RW_WORD  = 2'd3;

    // Port offsets from BASE
    localparam logic [1:0] OFF_CH0  = 2'd0;
    localparam logic [1:0] OFF_CH1  = 2'd1;
    localparam logic [1:0] OFF_CH2  = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    // M=2/6 -> rate generator, M=3/7 -> square wave, everything else -> mode 0
    function automatic logic [1:0] map_mode(input logic [2:0] m);
        return m[1] ? m[1:0] : MODE_IRQ;
    endfunction

endpackage

// File: rtl/pit8253_lite_channel.sv
// One 16-bit down-counter channel: reload register, mode, byte-order
// flip-flops, count latch and output. Strobes arrive already decoded for
// this channel; ce gates every state change. rd and the write strobes are
// never active together.
module pit_channel
    import pit_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       tick,
    input  logic       gate,
    input  logic       ctrl_wr,
    input  logic       data_wr,
    input  logic       rd,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       out
);

    logic [15:0] count_q, count_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] latch_q, latch_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  rw_q, rw_d;
    logic        armed_q, armed_d;
    logic        wff_q, wff_d;
    logic        rff_q, rff_d;
    logic        latched_q, latched_d;
    logic        out_q, out_d;
    logic        load_pending_q, load_pending_d;
    logic        gate_q, gate_d;

    logic        wr_done;
    logic        step;
    logic        rd_msb;
    logic [15:0] rd_src;

    // Read data: latched snapshot takes precedence over the live count
    always_comb begin
        rd_src = latched_q ? latch_q : count_q;
        rd_msb = (rw_q == RW_MSB) || ((rw_q == RW_WORD) && rff_q);
        dout   = rd_msb ? rd_src[15:8] : rd_src[7:0];
    end

    // Next state: control/data writes and reads first, then the count step
    always_comb begin
        count_d        = count_q;
        reload_d       = reload_q;
        latch_d        = latch_q;
        mode_d         = mode_q;
        rw_d           = rw_q;
        armed_d        = armed_q;
        wff_d          = wff_q;
        rff_d          = rff_q;
        latched_d      = latched_q;
        out_d          = out_q;
        load_pending_d = load_pending_q;
        gate_d         = ce ? gate : gate_q;
        wr_done        = 1'b0;

        if (ce && ctrl_wr) begin
            if (din[5:4] == RW_LATCH) begin
                // A second latch command is ignored until the latch is read out
                if (!latched_q) begin
                    latch_d   = count_q;
                    latched_d = 1'b1;
                end
            end else begin
                rw_d           = din[5:4];
                mode_d         = map_mode(din[3:1]);
                wff_d          = 1'b0;
                rff_d          = 1'b0;
                latched_d      = 1'b0;
                armed_d        = 1'b0;
                load_pending_d = 1'b0;
                out_d          = (map_mode(din[3:1]) != MODE_IRQ);
            end
        end else if (ce && data_wr) begin
            case (rw_q)
                RW_LSB: begin
                    reload_d = {8'h00, din};
                    wr_done  = 1'b1;
                end
                RW_MSB: begin
                    reload_d = {din, 8'h00};
                    wr_done  = 1'b1;
                end
                default: begin
                    if (!wff_q) begin
                        reload_d[7:0] = din;
                        wff_d         = 1'b1;
                    end else begin
                        reload_d[15:8] = din;
                        wff_d          = 1'b0;
                        wr_done        = 1'b1;
                    end
                end
            endcase
            if (wr_done) begin
                load_pending_d = 1'b1;
                if (mode_q == MODE_IRQ) begin
                    out_d = 1'b0;
                end
            end
        end else if (ce && rd) begin
            if (rw_q == RW_WORD) begin
                rff_d = !rff_q;
            end
            if (latched_q && ((rw_q != RW_WORD) || rff_q)) begin
                latched_d = 1'b0;
            end
        end

        // A control write or a completing reload on this clock swallows the tick
        step = ce && tick && gate && !ctrl_wr && !wr_done;

        if (step) begin
            if (load_pending_q) begin
                count_d        = (mode_q == MODE_SQW) ? {reload_q[15:1], 1'b0} : reload_q;
                load_pending_d = 1'b0;
                armed_d        = 1'b1;
            end else if (armed_q) begin
                case (mode_q)
                    MODE_RATE: begin
                        if (count_q == 16'd2) begin
                            count_d = 16'd1;
                            out_d   = 1'b0;
                        end else if (count_q == 16'd1) begin
                            count_d = reload_q;
                            out_d   = 1'b1;
                        end else begin
                            count_d = count_q - 16'd1;
                        end
                    end
                    MODE_SQW: begin
                        if (count_q == 16'd2) begin
                            count_d = reload_q & 16'hFFFE;
                            out_d   = !out_q;
                        end else begin
                            count_d = count_q - 16'd2;
                        end
                    end
                    default: begin
                        if (count_q == 16'd1) begin
                            out_d = 1'b1;
                        end
                        count_d = count_q - 16'd1;
                    end
                endcase
            end
        end

        // Gate rising edge restarts a programmed rate/square-wave counter
        if (ce && gate && !gate_q && !ctrl_wr && (mode_q != MODE_IRQ)
            && (armed_q || load_pending_q)) begin
            load_pending_d = 1'b1;
        end
    end

    // Channel state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q        <= 16'h0000;
            reload_q       <= 16'h0000;
            latch_q        <= 16'h0000;
            mode_q         <= MODE_IRQ;
            rw_q           <= RW_WORD;
            armed_q        <= 1'b0;
            wff_q          <= 1'b0;
            rff_q          <= 1'b0;
            latched_q      <= 1'b0;
            out_q          <= 1'b0;
            load_pending_q <= 1'b0;
            gate_q         <= 1'b0;
        end else begin
            count_q        <= count_d;
            reload_q       <= reload_d;
            latch_q        <= latch_d;
            mode_q         <= mode_d;
            rw_q           <= rw_d;
            armed_q        <= armed_d;
            wff_q          <= wff_d;
            rff_q          <= rff_d;
            latched_q      <= latched_d;
            out_q          <= out_d;
            load_pending_q <= load_pending_d;
            gate_q         <= gate_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/pit8253_lite.sv
// Port-mapped 8253-style interval timer: address decode for BASE..BASE+3,
// three counter channels, read mux and the registered read-data port.
// Channel 0 drives IRQ0, channel 2 (gated by gate2) drives the speaker;
// channel 1's output is brought out on out1 for observation.
module pit8253_lite
    import pit_pkg::*;
#(
    parameter logic [15:0] BASE = 16'h0040
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        tick,
    input  logic [15:0] pa,
    input  logic        pr,
    input  logic        pw,
    input  logic [7:0]  pd,
    output logic [7:0]  pout,
    output logic        psel,
    input  logic        gate2,
    output logic        out0,
    output logic        out1,
    output logic        out2
);

    logic [15:0] offset;
    logic [1:0]  reg_sel;
    logic        is_ctrl;
    logic [2:0]  ctrl_wr;
    logic [2:0]  data_wr;
    logic [2:0]  rd;
    logic [2:0]  ch_gate;
    logic [2:0]  ch_out;
    logic [7:0]  ch_dout [3];
    logic [7:0]  pout_q, pout_d;

    assign offset  = pa - BASE;
    assign psel    = (offset[15:2] == 14'd0);
    assign reg_sel = offset[1:0];
    assign is_ctrl = psel && (reg_sel == OFF_CTRL);
    assign ch_gate = {gate2, 1'b1, 1'b1};

    // Per-channel strobes; a simultaneous read and write performs the write only
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ctrl_wr[i] = pw && is_ctrl && (pd[7:6] == 2'(i));
            data_wr[i] = pw && psel && (reg_sel == 2'(i));
            rd[i]      = pr && !pw && psel && (reg_sel == 2'(i));
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        pit_channel u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .ce      (ce),
            .tick    (tick),
            .gate    (ch_gate[i]),
            .ctrl_wr (ctrl_wr[i]),
            .data_wr (data_wr[i]),
            .rd      (rd[i]),
            .din     (pd),
            .dout    (ch_dout[i]),
            .out     (ch_out[i])
        );
    end

    // Read mux; pout updates only on an accepted read and otherwise holds
    always_comb begin
        pout_d = pout_q;
        if (ce && pr && !pw && psel) begin
            case (reg_sel)
                OFF_CH0: pout_d = ch_dout[0];
                OFF_CH1: pout_d = ch_dout[1];
                OFF_CH2: pout_d = ch_dout[2];
                default: pout_d = 8'hFF;
            endcase
        end
    end

    // Registered read data, one clock after the read strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pout_q <= 8'hFF;
        end else begin
            pout_q <= pout_d;
        end
    end

    assign pout = pout_q;
    assign out0 = ch_out[0];
    assign out1 = ch_out[1];
    assign out2 = ch_out[2];

endmodule

// File: doc/pit8253_lite.md
Name: pit8253_lite

Overview:
- Port-mapped programmable interval timer on the core's I/O bus. It consumes the core's pa/pr/pw strobes and write data, and returns read data for the core's pin input.
- Three 16-bit binary down-counters, channels 0..2, compatible with the 8253 at ports BASE..BASE+3.
- Channel 0 output drives IRQ0. Channel 2 output, gated by gate2, drives the speaker.
- Counting advances on an external tick strobe (1.193 MHz equivalent), so the block runs in the core clock domain.

Parameters:
- BASE, 16'h0040: first I/O address. Counters are at BASE+0..2; the control word is at BASE+3.

Ports:
- clock  in  1: core clock. All state changes on the rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- ce  in  1: clock enable. When 0, all state holds and pr/pw/tick are ignored.
- tick  in  1: one-clock count strobe.
- pa  in  16: I/O port address.
- pr  in  1: I/O read strobe, one clock wide.
- pw  in  1: I/O write strobe, one clock wide.
- pd  in  8: I/O write data (core out bus).
- pout  out  8: I/O read data, registered.
- psel  out  1: combinational; 1 when pa is in BASE..BASE+3.
- gate2  in  1: channel 2 gate. Channels 0 and 1 are permanently gated on.
- out0  out  1: channel 0 output (IRQ0).
- out2  out  1: channel 2 output (speaker).

Behaviour:
- Reset: every channel has count=0, reload=0, mode=0, rw=3, armed=0, wff=0, rff=0, latched=0, out=0. pout=8'hFF.
- Control write (pw & pa==BASE+3): SC=pd[7:6], RW=pd[5:4], M=pd[3:1]. pd[0] (BCD) is ignored.
  - SC=3 is ignored entirely.
  - RW=00 with no latch pending: snapshot count into latch and set latched. Mode is unchanged. A latch command while latched=1 is ignored.
  - RW≠00: set rw and mode, then wff=0, rff=0, latched=0, armed=0.
  - Mode mapping: M=6→2, M=7→3, M in {1,4,5}→0.
  - Output level after a mode write: mode 0 → out=0; modes 2/3 → out=1.
- Data write (pw & pa==BASE+n, n<3):
  - rw=01: reload={8'h00,pd}.
  - rw=10: reload={pd,8'h00}.
  - rw=11: first byte sets the LSB and toggles wff; second byte sets the MSB and toggles wff.
  - Reload completes after the single byte (rw 01/10) or after the MSB (rw 11). On completion set load_pending.
  - In mode 0, completion also forces out=0.
- Count step, on a clock with ce & tick & gate:
  - If load_pending: count←reload (reload 0 means 65536). In mode 3, bit0 is cleared first. Then clear load_pending and set armed.
  - Else if armed, by mode:
    - Mode 0: count−1 with 16-bit wrap. out←1 on the 1→0 transition and stays high until reprogrammed.
    - Mode 2: when count==2, count becomes 1 and out←0. When count==1, count←reload and out←1. Otherwise count−1.
    - Mode 3: when count==2, count←reload&FFFE and out toggles. Otherwise count−2.
    - Reload 1 in mode 3 behaves as 65536.
  - A step is never applied on the same clock as a completing data write. The load takes the next tick.
  - Channel 2 with gate2=0 holds count. When gate2 rises in modes 2/3, load_pending is set again.
- Read (pr & psel): pout is valid on the clock after pr, matching memory read latency.
  - BASE+3 returns 8'hFF.
  - If latched: return the latch LSB, then the MSB on the following read, following rw order. Clear latched after the final byte.
  - If not latched: return the live count bytes in rw order, toggling rff for rw=11.
- Write priority: a control write and a tick on the same clock: the control write wins and that channel ignores the tick.
- Concurrent access: pr and pw in the same clock perform the write only; pout holds.
- Reset asserted mid-count returns every channel to its reset state immediately (asynchronous).

Decomposition:
- Package pit_pkg:
  - Mode constants MODE_IRQ=0, MODE_RATE=2, MODE_SQW=3.
  - RW encodings RW_LATCH, RW_LSB, RW_MSB, RW_WORD.
  - Port offset constants.
- Sub-module pit_channel holds one channel (count, reload, mode, flip-flops, latch, out) with write/read/tick strobes and an 8-bit data path.
- The top level contains the address decode, three pit_channel instances, the read mux, and the pout register.

Test Plan:
- Reset, then read BASE+0 with rw=3: pout=00 then 00; out0=0, out2=0, psel=0 for pa=0x0060.
- Control 0x34 (ch0, word, mode2), write 04,00, then 10 ticks: one load tick, then out0 low for exactly one tick every 4 ticks. count sequence 4,3,2,1,4.
- Control 0xB6 (ch2, word, mode3), write 06,00, gate2=1, then 20 ticks: out2 toggles every 3 ticks. Drop gate2 to 0: count and out2 freeze.
- Control 0x30 (ch0, mode0), write 03,00, then 5 ticks: out0 rises on the tick where count reaches 0 (load+3) and stays 1 through the wrap to FFFF.
- Ch0 running in mode 2 with reload 0x1234: write control 0x00 (latch), apply 3 more ticks, then two reads return the latched LSB/MSB, not the live count. A second latch command while latched is ignored.
- Ch0 control write on the same clock as a tick: that tick is ignored, the mode changes, and out0 takes the new initial level. Reset pulse mid-count: all outputs 0 immediately and pout=FF.
